// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU run controller: command/report codes,
// FSM states and the breakpoint slot layout.
package cpu_run_ctrl_pkg;

  localparam int NBP = 4;
  localparam int BP_IW = $clog2(NBP);

  typedef enum logic [1:0] {
    OP_STEP  = 2'd0,
    OP_RUN   = 2'd1,
    OP_HALT  = 2'd2,
    OP_BP_WR = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    RC_STEP_DONE = 2'd0,
    RC_BP_HIT    = 2'd1,
    RC_HALTED    = 2'd2
  } rpt_code_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HI   = 3'd1,
    ST_LO   = 3'd2,
    ST_CHK  = 3'd3,
    ST_RPT  = 3'd4
  } state_e;

  typedef struct packed {
    logic [29:0] waddr;
    logic        en;
  } bp_slot_t;

  // BP_WR payload: [31:2] word address, [0] enable; bit 1 is ignored.
  function automatic bp_slot_t decode_bp(input logic [31:0] arg);
    bp_slot_t s;
    s.waddr = arg[31:2];
    s.en    = arg[0];
    return s;
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Command and stop-report handshakes between the debug command processor
// (master) and the run controller (slave).
interface cpu_run_ctrl_if;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic        rpt_vld;
  logic        rpt_rdy;
  logic [1:0]  rpt_code;
  logic [31:0] rpt_pc;

  modport master (
    output cmd_vld, cmd_op, cmd_idx, cmd_arg, rpt_rdy,
    input  cmd_rdy, rpt_vld, rpt_code, rpt_pc
  );

  modport slave (
    input  cmd_vld, cmd_op, cmd_idx, cmd_arg, rpt_rdy,
    output cmd_rdy, rpt_vld, rpt_code, rpt_pc
  );
endinterface

// File: rtl/cpu_run_ctrl_bp_match.sv
// Breakpoint slot registers with a parallel word-address comparator;
// o_hit is high when any enabled slot matches the presented word address.
module bp_match
  import cpu_run_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [BP_IW-1:0] i_wr_idx,
  input  bp_slot_t         i_wr_slot,
  input  logic [29:0]      i_npc_w,
  output logic             o_hit
);

  logic [NBP-1:0] w_slot_hit;

  generate
    for (genvar gi = 0; gi < NBP; gi++) begin : g_slot
      bp_slot_t r_slot;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_slot <= '0;
        end else if (i_wr_en && (i_wr_idx == BP_IW'(gi))) begin
          r_slot <= i_wr_slot;
        end
      end

      assign w_slot_hit[gi] = r_slot.en && (r_slot.waddr == i_npc_w);
    end
  endgenerate

  assign o_hit = |w_slot_hit;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Gated CPU clock controller with STEP/RUN/HALT and 4 PC breakpoints.
// Optional cycle counter enabled by defining CPU_RUN_CTRL_CYCCNT_EN.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int HALF = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  cpu_run_ctrl_if.slave        bus,
  input  logic [31:0]          npc,
  input  logic                 pc_chk,
  output logic                 clk_cpu,
  output logic                 running,
  output logic [31:0]          cyc_cnt
);

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(HALF - 1);

  state_e         r_state;
  state_e         w_state_next;
  rpt_code_e      w_rpt_code_next;
  logic [CW-1:0]  r_cnt;
  logic           r_run_mode;
  logic           r_halt_pend;
  logic           r_clk_cpu;
  logic [1:0]     r_rpt_code;
  logic [31:0]    r_rpt_pc;
  logic           w_cmd_rdy;
  logic           w_cmd_acc;
  logic           w_bp_hit;
  logic           w_rpt_entry;
  logic           w_phase_entry;
  logic           w_unused_bits;

  assign w_cmd_acc     = bus.cmd_vld && w_cmd_rdy;
  assign w_rpt_entry   = (w_state_next == ST_RPT) && (r_state != ST_RPT);
  assign w_phase_entry = (w_state_next != r_state) &&
                         ((w_state_next == ST_HI) || (w_state_next == ST_LO));
  assign w_unused_bits = &{1'b0, npc[1:0]};

  bp_match u_bp_match (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_cmd_acc && (bus.cmd_op == OP_BP_WR)),
    .i_wr_idx  (bus.cmd_idx),
    .i_wr_slot (decode_bp(bus.cmd_arg)),
    .i_npc_w   (npc[31:2]),
    .o_hit     (w_bp_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_rpt_code_next = RC_STEP_DONE;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_acc) begin
          case (bus.cmd_op)
            OP_STEP, OP_RUN: w_state_next = ST_HI;
            OP_HALT: begin
              w_state_next    = ST_RPT;
              w_rpt_code_next = RC_HALTED;
            end
            default: w_state_next = ST_IDLE;
          endcase
        end
      end
      ST_HI: begin
        if (r_cnt == '0) w_state_next = ST_LO;
      end
      ST_LO: begin
        if (r_cnt == '0) w_state_next = r_run_mode ? ST_CHK : ST_RPT;
      end
      ST_CHK: begin
        // A pending halt outranks a breakpoint seen in the same check slot.
        if (r_halt_pend) begin
          w_state_next    = ST_RPT;
          w_rpt_code_next = RC_HALTED;
        end else if (pc_chk && w_bp_hit) begin
          w_state_next    = ST_RPT;
          w_rpt_code_next = RC_BP_HIT;
        end else begin
          w_state_next = ST_HI;
        end
      end
      ST_RPT: begin
        if (bus.rpt_rdy) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cmd_rdy = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_IDLE:               w_cmd_rdy = 1'b1;
        ST_HI, ST_LO, ST_CHK:  w_cmd_rdy = (bus.cmd_op == OP_HALT) ||
                                           (bus.cmd_op == OP_BP_WR);
        default:               w_cmd_rdy = 1'b0;
      endcase
    end
  end

  assign bus.cmd_rdy  = w_cmd_rdy;
  assign bus.rpt_vld  = (r_state == ST_RPT);
  assign bus.rpt_code = r_rpt_code;
  assign bus.rpt_pc   = r_rpt_pc;
  assign running      = (r_state != ST_IDLE) && (r_state != ST_RPT);
  assign clk_cpu      = r_clk_cpu;

  // clk_cpu is registered from the next state so it is glitch-free and
  // aligned with the HI state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_run_mode  <= 1'b0;
      r_halt_pend <= 1'b0;
      r_clk_cpu   <= 1'b0;
      r_rpt_code  <= 2'd0;
      r_rpt_pc    <= 32'd0;
    end else begin
      r_clk_cpu <= (w_state_next == ST_HI);

      if (w_phase_entry) begin
        r_cnt <= CNT_LOAD;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end

      if ((r_state == ST_IDLE) && w_cmd_acc) begin
        r_run_mode <= (bus.cmd_op == OP_RUN);
      end

      if (w_rpt_entry) begin
        r_halt_pend <= 1'b0;
      end else if (w_cmd_acc && (bus.cmd_op == OP_HALT) && (r_state != ST_IDLE)) begin
        r_halt_pend <= 1'b1;
      end

      if (w_rpt_entry) begin
        r_rpt_code <= w_rpt_code_next;
        r_rpt_pc   <= npc;
      end
    end
  end

`ifdef CPU_RUN_CTRL_CYCCNT_EN
  logic [31:0] r_cyc_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cyc_cnt <= 32'd0;
    end else if ((w_state_next == ST_HI) && (r_state != ST_HI) && (r_cyc_cnt != '1)) begin
      r_cyc_cnt <= r_cyc_cnt + 32'd1;
    end
  end

  assign cyc_cnt = r_cyc_cnt;
`else
  assign cyc_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed plus randomized bench for cpu_run_ctrl with a behavioural CPU
// (npc advances one word per clk_cpu rising edge) and breakpoint model.
module tb_cpu_run_ctrl;
  import cpu_run_ctrl_pkg::*;

  localparam int HALF = 2;
  localparam int PER  = 2 * HALF + 1;
`ifdef CPU_RUN_CTRL_CYCCNT_EN
  localparam bit CYC_EN = 1'b1;
`else
  localparam bit CYC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] npc;
  logic        pc_chk;
  logic        clk_cpu;
  logic        running;
  logic [31:0] cyc_cnt;

  cpu_run_ctrl_if bus ();

  cpu_run_ctrl #(.HALF(HALF)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .npc     (npc),
    .pc_chk  (pc_chk),
    .clk_cpu (clk_cpu),
    .running (running),
    .cyc_cnt (cyc_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural CPU: one word of progress per clk_cpu rising edge.
  int          pulse_cnt = 0;
  int          pulse_base = 0;
  logic [31:0] npc_base = 32'h3000;
  bit          cpu_adv = 1'b0;
  always @(posedge clk_cpu) pulse_cnt <= pulse_cnt + 1;
  assign npc = npc_base + (cpu_adv ? 32'(4 * (pulse_cnt - pulse_base)) : 32'd0);

  // High-phase width monitor: every complete pulse must last HALF cycles.
  int hi_run = 0;
  int bad_width = 0;
  always @(negedge clk) begin
    if (rst) begin
      hi_run <= 0;
    end else if (clk_cpu) begin
      hi_run <= hi_run + 1;
    end else begin
      if (hi_run != 0 && hi_run != HALF) bad_width <= bad_width + 1;
      hi_run <= 0;
    end
  end

  // Breakpoint model
  logic [29:0] m_addr [NBP];
  bit          m_en   [NBP];
  int          cyc_base = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < NBP; s++) begin
      m_addr[s] = '0;
      m_en[s]   = 1'b0;
    end
  endtask

  // Presents a command from mid-cycle, returns just after the accepting edge.
  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [1:0] idx,
                        input logic [31:0] arg);
    int n = 0;
    bus.cmd_op  = op;
    bus.cmd_idx = idx;
    bus.cmd_arg = arg;
    bus.cmd_vld = 1'b1;
    #1;
    while (bus.cmd_rdy !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_cmd_rdy"}, bus.cmd_rdy, 1);
    @(posedge clk);
    #1 bus.cmd_vld = 1'b0;
    if (op == OP_BP_WR) begin
      m_addr[idx] = arg[31:2];
      m_en[idx]   = arg[0];
    end
    $display("[TB] cmd %s op=%0d idx=%0d arg=%08h", tag, op, idx, arg);
  endtask

  task automatic wait_rpt();
    int n = 0;
    while (bus.rpt_vld !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic ack_rpt(input string tag, input logic [1:0] code, input logic [31:0] pc);
    wait_rpt();
    check({tag, "_vld"}, bus.rpt_vld, 1);
    check({tag, "_code"}, bus.rpt_code, code);
    check({tag, "_pc"}, bus.rpt_pc, pc);
    $display("[TB] rpt %s code=%0d pc=%08h", tag, bus.rpt_code, bus.rpt_pc);
    bus.rpt_rdy = 1'b1;
    @(posedge clk);
    #1 bus.rpt_rdy = 1'b0;
    @(negedge clk);
    check({tag, "_idle_vld"}, bus.rpt_vld, 0);
    check({tag, "_idle_run"}, running, 0);
  endtask

  task automatic wait_pulses(input string tag, input int p0, input int k);
    int n = 0;
    while ((pulse_cnt - p0) < k && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_pulses_reached"}, 32'((pulse_cnt - p0) >= k), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_model();
    cyc_base = pulse_cnt;
  endtask

  initial begin
    int p0;
    int exp_k;
    logic [31:0] base;
    logic [31:0] a;
    bit is_step;

    rst = 1'b1;
    pc_chk = 1'b1;
    bus.cmd_vld = 1'b1;
    bus.cmd_op = OP_STEP;
    bus.cmd_idx = 2'd0;
    bus.cmd_arg = 32'd0;
    bus.rpt_rdy = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);

    check("rst_clk_cpu", clk_cpu, 0);
    check("rst_cmd_rdy", bus.cmd_rdy, 0);
    check("rst_rpt_vld", bus.rpt_vld, 0);
    check("rst_rpt_code", bus.rpt_code, 0);
    check("rst_rpt_pc", bus.rpt_pc, 0);
    check("rst_running", running, 0);
    check("rst_cyc_cnt", cyc_cnt, 0);
    bus.cmd_vld = 1'b0;
    rst = 1'b0;
    cyc_base = pulse_cnt;
    @(negedge clk);
    check("idle_cmd_rdy", bus.cmd_rdy, 1);

    // STEP latency: high for HALF cycles, low HALF, report at 2*HALF+1.
    npc_base = 32'h3000;
    cpu_adv = 1'b0;
    do_cmd("step", OP_STEP, 2'd0, 32'd0);
    for (int k = 1; k <= PER; k++) begin
      @(negedge clk);
      check($sformatf("step_clk_t%0d", k), clk_cpu, 32'(k <= HALF));
      check($sformatf("step_vld_t%0d", k), bus.rpt_vld, 32'(k == PER));
    end
    ack_rpt("step", RC_STEP_DONE, 32'h3000);

    // HALT in IDLE reports on the next cycle.
    do_cmd("halt_idle", OP_HALT, 2'd0, 32'd0);
    @(negedge clk);
    check("halt_idle_next", bus.rpt_vld, 1);
    ack_rpt("halt_idle", RC_HALTED, 32'h3000);

    // Breakpoint at 0x300C in slot 1, RUN from 0x3000.
    do_cmd("bp_wr1", OP_BP_WR, 2'd1, 32'h0000_300D);
    npc_base = 32'h3000;
    pulse_base = pulse_cnt;
    cpu_adv = 1'b1;
    p0 = pulse_cnt;
    do_cmd("run_bp", OP_RUN, 2'd0, 32'd0);
    ack_rpt("run_bp", RC_BP_HIT, 32'h300C);
    check("run_bp_pulses", pulse_cnt - p0, 3);

    // RUN starting on the breakpoint, HALT 10 cycles later.
    npc_base = 32'h300C;
    pulse_base = pulse_cnt;
    p0 = pulse_cnt;
    do_cmd("run_halt", OP_RUN, 2'd0, 32'd0);
    repeat (10) @(negedge clk);
    do_cmd("run_halt_h", OP_HALT, 2'd0, 32'd0);
    wait_rpt();
    check("run_halt_pulses", pulse_cnt - p0, 10 / PER + 1);
    ack_rpt("run_halt", RC_HALTED, 32'h300C + 32'(4 * (pulse_cnt - p0)));
    p0 = pulse_cnt;
    repeat (20) @(negedge clk);
    check("after_halt_no_pulse", pulse_cnt - p0, 0);
    check("after_halt_clk", clk_cpu, 0);
    check("width_ok_1", bad_width, 0);

    // Report held off: everything frozen while rpt_rdy is low.
    cpu_adv = 1'b0;
    npc_base = 32'h4000;
    do_cmd("hold", OP_STEP, 2'd0, 32'd0);
    wait_rpt();
    p0 = pulse_cnt;
    bus.cmd_op = OP_RUN;
    bus.cmd_vld = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_vld", bus.rpt_vld, 1);
      check("hold_code", bus.rpt_code, RC_STEP_DONE);
      check("hold_pc", bus.rpt_pc, 32'h4000);
      check("hold_cmd_rdy", bus.cmd_rdy, 0);
      check("hold_clk", clk_cpu, 0);
    end
    bus.cmd_vld = 1'b0;
    check("hold_no_pulse", pulse_cnt - p0, 0);
    ack_rpt("hold", RC_STEP_DONE, 32'h4000);

    // Reset mid-pulse drops clk_cpu at once and clears the breakpoints.
    cpu_adv = 1'b1;
    npc_base = 32'h3000;
    pulse_base = pulse_cnt;
    do_cmd("run_rst", OP_RUN, 2'd0, 32'd0);
    begin
      int n = 0;
      while (clk_cpu !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    check("rst_mid_hi", clk_cpu, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_clk", clk_cpu, 0);
    check("rst_mid_cmd_rdy", bus.cmd_rdy, 0);
    check("rst_mid_running", running, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_model();
    cyc_base = pulse_cnt;
    npc_base = 32'h3000;
    pulse_base = pulse_cnt;
    p0 = pulse_cnt;
    do_cmd("run_nobp", OP_RUN, 2'd0, 32'd0);
    wait_pulses("run_nobp", p0, 6);
    check("run_nobp_no_rpt", bus.rpt_vld, 0);
    do_cmd("run_nobp_h", OP_HALT, 2'd0, 32'd0);
    wait_rpt();
    ack_rpt("run_nobp", RC_HALTED, 32'h3000 + 32'(4 * (pulse_cnt - p0)));
    check("cyc_after_run", cyc_cnt, CYC_EN ? 32'(pulse_cnt - cyc_base) : 32'd0);

    // Three STEPs after reset.
    do_reset();
    check("cyc_reset", cyc_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      npc_base = 32'h5000;
      pulse_base = pulse_cnt;
      do_cmd("step3", OP_STEP, 2'd0, 32'd0);
      ack_rpt("step3", RC_STEP_DONE, 32'h5004);
    end
    check("cyc_3steps", cyc_cnt, CYC_EN ? 32'd3 : 32'd0);

    // Breakpoint written while running takes effect at a later check.
    npc_base = 32'h6000;
    pulse_base = pulse_cnt;
    p0 = pulse_cnt;
    do_cmd("run_live", OP_RUN, 2'd0, 32'd0);
    wait_pulses("run_live", p0, 1);
    do_cmd("bp_live", OP_BP_WR, 2'd2, 32'h0000_6011);
    ack_rpt("run_live", RC_BP_HIT, 32'h6010);
    check("run_live_pulses", pulse_cnt - p0, 4);

    // Randomized transactions against the breakpoint model.
    for (int it = 0; it < 16; it++) begin
      base = $urandom & 32'hFFFF_FFFC;
      for (int w = 0; w < int'($urandom_range(1, 3)); w++) begin
        a = base + 32'(4 * $urandom_range(1, 8));
        do_cmd("rnd_bp", OP_BP_WR, 2'($urandom_range(0, 3)),
               {a[31:2], 1'b0, 1'($urandom_range(0, 1))});
      end
      pc_chk = ($urandom_range(0, 3) != 0);
      is_step = ($urandom_range(0, 3) == 0);
      exp_k = 0;
      if (!is_step && pc_chk) begin
        for (int k = 1; k <= 40 && exp_k == 0; k++) begin
          for (int s = 0; s < NBP; s++) begin
            a = base + 32'(4 * k);
            if (m_en[s] && m_addr[s] == a[31:2]) exp_k = k;
          end
        end
      end
      npc_base = base;
      pulse_base = pulse_cnt;
      p0 = pulse_cnt;
      if (is_step) begin
        do_cmd("rnd_step", OP_STEP, 2'd0, 32'd0);
        ack_rpt("rnd_step", RC_STEP_DONE, base + 32'd4);
        check("rnd_step_pulses", pulse_cnt - p0, 1);
      end else if (exp_k != 0) begin
        do_cmd("rnd_run", OP_RUN, 2'd0, 32'd0);
        ack_rpt("rnd_bp", RC_BP_HIT, base + 32'(4 * exp_k));
        check("rnd_bp_pulses", pulse_cnt - p0, exp_k);
      end else begin
        do_cmd("rnd_run", OP_RUN, 2'd0, 32'd0);
        wait_pulses("rnd_halt", p0, 5);
        do_cmd("rnd_halt_h", OP_HALT, 2'd0, 32'd0);
        wait_rpt();
        ack_rpt("rnd_halt", RC_HALTED, base + 32'(4 * (pulse_cnt - p0)));
      end
      check("rnd_cyc", cyc_cnt, CYC_EN ? 32'(pulse_cnt - cyc_base) : 32'd0);
    end
    pc_chk = 1'b1;
    check("width_ok_end", bad_width, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 The block SHALL have parameter HALF, default 2, giving the number of clk cycles in each clk_cpu half-period (minimum 1).
REQ-003 clk  in  1  block clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 cmd_vld  in  1; cmd_rdy  out  1  command handshake from the debug command processor.
REQ-006 cmd_op  in  2  command: 0 STEP, 1 RUN, 2 HALT, 3 BP_WR.
REQ-007 cmd_idx  in  2  breakpoint slot for BP_WR.
REQ-008 cmd_arg  in  32  BP_WR payload: [31:2] word address, [0] enable.
REQ-009 npc  in  32  CPU next-PC.
REQ-010 pc_chk  in  1  npc valid for breakpoint compare.
REQ-011 clk_cpu  out  1  gated CPU clock, registered.
REQ-012 running  out  1  high in every state except IDLE and RPT.
REQ-013 rpt_vld  out  1; rpt_rdy  in  1  stop-report handshake.
REQ-014 rpt_code  out  2  stop reason: 0 STEP_DONE, 1 BP_HIT, 2 HALTED.
REQ-015 rpt_pc  out  32  npc captured on entry to RPT.
REQ-016 cyc_cnt  out  32  count of CPU rising edges issued (see Configuration).

Function
REQ-017 The FSM SHALL have states IDLE, HI, LO, CHK and RPT; clk_cpu SHALL be 1 only in HI.
REQ-018 HI and LO SHALL each last exactly HALF cycles, counted by an internal down-counter.
REQ-019 In IDLE, cmd_rdy SHALL be 1 for all ops; in HI, LO and CHK, cmd_rdy SHALL be 1 only when cmd_op is HALT or BP_WR; in RPT, cmd_rdy SHALL be 0.
REQ-020 An accepted STEP SHALL run IDLE->HI->LO->RPT with rpt_code 0; halt_pend SHALL be cleared at RPT entry.
REQ-021 An accepted RUN SHALL enter HI and loop HI->LO->CHK->HI; the first pulse SHALL always be issued, so a RUN started on a breakpoint makes progress.
REQ-022 CHK SHALL last 1 cycle with priority halt_pend (code 2), then pc_chk with npc[31:2] matching any enabled slot (code 1), then HI.
REQ-023 An accepted HALT in IDLE SHALL enter RPT with code 2 on the next cycle.
REQ-024 An accepted HALT while running SHALL set halt_pend without truncating the current clk_cpu pulse.
REQ-025 BP_WR SHALL be accepted in any state except RPT and SHALL write the slot on the accept cycle; a slot written during RUN SHALL take effect at the next CHK.
REQ-026 In RPT, rpt_vld SHALL be 1 and rpt_code/rpt_pc SHALL be stable until rpt_vld&&rpt_rdy, after which the FSM SHALL return to IDLE.
REQ-027 Latency: a STEP accepted on edge t SHALL give clk_cpu high during t+1..t+HALF and rpt_vld at t+2*HALF+1.

Reset
REQ-028 rst SHALL asynchronously force state IDLE, clk_cpu 0, cmd_rdy 0 while asserted, rpt_vld 0, rpt_code 0, rpt_pc 0, running 0, halt_pend 0, all 4 breakpoint slots disabled, and cyc_cnt 0.
REQ-029 rst asserted mid-pulse SHALL drop clk_cpu without waiting for a clk edge.

Configuration
REQ-030 With CPU_RUN_CTRL_CYCCNT_EN defined, cyc_cnt SHALL increment on each HI entry, saturate at 0xFFFFFFFF, and be cleared only by rst.
REQ-031 Without CPU_RUN_CTRL_CYCCNT_EN, the counter logic SHALL be absent and cyc_cnt SHALL be constant 0.

Structure
REQ-032 Package cpu_run_ctrl_pkg SHALL hold the op codes, report codes, state enum and NBP=4.
REQ-033 Sub-module bp_match SHALL hold the 4-slot breakpoint registers and the parallel comparator, producing a hit signal.

Verification
REQ-034 HALF=2, npc=0x3000, STEP -> clk_cpu high 2 cycles and low 2 cycles, then rpt_vld with code 0 and rpt_pc 0x3000 at t+5.
REQ-035 BP_WR idx1 arg 0x0000300D, RUN, npc advancing +4 from 0x3000 per pulse with pc_chk=1 -> 3 pulses, then code 1 and rpt_pc 0x300C.
REQ-036 RUN, then HALT 10 cycles later -> the current pulse completes, code 2 is reported, clk_cpu stays 0 afterwards.
REQ-037 rpt_rdy held 0 for 20 cycles -> rpt_vld and fields stable, cmd_rdy 0, no clk_cpu pulses; rpt_rdy=1 -> IDLE.
REQ-038 rst asserted during HI -> clk_cpu 0 immediately; a subsequent RUN does not stop at 0x300C.
REQ-039 With the macro, 3 STEPs -> cyc_cnt=3; without the macro, cyc_cnt=0.
